// File: rtl/soc_run_ctrl_pkg.sv
// Shared definitions for the SoC run controller: FSM state encoding,
// core reset polarity constants and a counter-width helper.
package soc_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_SEQ  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_t;

  // Core-side reset polarity: 1 holds a core in reset.
  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  // Width of a counter that must reach limit-1; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/soc_rst_seq.sv
// Reset release sequencer: holds every core reset for RST_HOLD cycles, then
// releases one domain every STAGGER cycles, lowest index first.
module soc_rst_seq
  import soc_run_ctrl_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int RST_HOLD = 10,
  parameter int STAGGER  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  run_state_t        state,
  output logic [NUM_CH-1:0] core_rst,
  output logic              hold_end,
  output logic              seq_end
);

  localparam int HOLD_W = cnt_width(RST_HOLD);
  localparam int STAG_W = cnt_width(STAGGER);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [STAG_W-1:0] stag_cnt;
  logic [NUM_CH-1:0] released;
  logic              found;

  // Release pattern: the lowest domain still held in reset is cleared.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    released = core_rst;
    found    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && core_rst[k] == RST_ENABLE) begin
        released[k] = RST_DISABLE;
        found       = 1'b1;
      end
    end
  end

  assign hold_end = (state == ST_HOLD) && (hold_cnt == HOLD_LAST);
  assign seq_end  = (state == ST_SEQ) && (stag_cnt == STAG_LAST) &&
                    (released == {NUM_CH{RST_DISABLE}});

  // Hold/stagger counters and the per-domain release register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
      stag_cnt <= '0;
      core_rst <= {NUM_CH{RST_ENABLE}};
    end else if (restart) begin
      hold_cnt <= '0;
      stag_cnt <= '0;
      core_rst <= {NUM_CH{RST_ENABLE}};
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_end) begin
            hold_cnt <= '0;
            core_rst <= released;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_SEQ: begin
          if (stag_cnt == STAG_LAST) begin
            stag_cnt <= '0;
            core_rst <= released;
          end else begin
            stag_cnt <= stag_cnt + STAG_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/soc_run_ctrl.sv
// Run controller for the minimal SoC: sequences core resets, counts run
// cycles, ends the run on halt or cycle limit, and supports soft restart.
module soc_run_ctrl
  import soc_run_ctrl_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int RST_HOLD   = 10,
  parameter int STAGGER    = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_i,
  input  logic              restart_i,
  output logic [NUM_CH-1:0] core_rst_o,
  output logic              run_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  localparam bit LIMITED = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(MAX_CYCLES - 1);

  run_state_t       state;
  run_state_t       state_next;
  logic [CNT_W-1:0] cnt_next;
  logic             timeout_next;
  logic             hold_end;
  logic             seq_end;

  soc_rst_seq #(
    .NUM_CH   (NUM_CH),
    .RST_HOLD (RST_HOLD),
    .STAGGER  (STAGGER)
  ) u_rst_seq (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart_i),
    .state    (state),
    .core_rst (core_rst_o),
    .hold_end (hold_end),
    .seq_end  (seq_end)
  );

  // Next state, next cycle count and exit cause; restart overrides everything.
  always_comb begin
    state_next   = state;
    cnt_next     = cycle_cnt_o;
    timeout_next = timeout_o;
    if (restart_i) begin
      state_next   = ST_HOLD;
      cnt_next     = '0;
      timeout_next = 1'b0;
    end else begin
      case (state)
        ST_HOLD: if (hold_end) state_next = (NUM_CH == 1) ? ST_RUN : ST_SEQ;
        ST_SEQ:  if (seq_end)  state_next = ST_RUN;
        ST_RUN: begin
          if (cycle_cnt_o != {CNT_W{1'b1}}) cnt_next = cycle_cnt_o + CNT_W'(1);
          // Halt wins over a coincident limit.
          if (halt_i) begin
            state_next   = ST_DONE;
            timeout_next = 1'b0;
          end else if (LIMITED && cycle_cnt_o == LIMIT_LAST) begin
            state_next   = ST_DONE;
            timeout_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State register plus registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_HOLD;
      cycle_cnt_o <= '0;
      run_o       <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state       <= state_next;
      cycle_cnt_o <= cnt_next;
      run_o       <= (state_next == ST_RUN);
      done_o      <= (state_next == ST_DONE);
      timeout_o   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_soc_run_ctrl.sv
// Self-checking bench for soc_run_ctrl: directed scenarios plus a random
// halt/restart phase, compared against a time-based behavioural model.
`timescale 1ns/1ps
module tb_soc_run_ctrl;

  localparam int NUM_CH     = 2;
  localparam int RST_HOLD   = 10;
  localparam int STAGGER    = 4;
  localparam int CNT_W      = 32;
  localparam int MAX_CYCLES = 50;
  localparam int REL_LAST   = RST_HOLD + (NUM_CH - 1) * STAGGER;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              halt_i = 1'b0;
  logic              restart_i = 1'b0;
  logic [NUM_CH-1:0] core_rst_o;
  logic              run_o, done_o, timeout_o;
  logic [CNT_W-1:0]  cycle_cnt_o;

  logic              rst_nl = 1'b0;
  logic              halt_nl = 1'b0;
  logic              restart_nl = 1'b0;
  logic [NUM_CH-1:0] core_rst_nl;
  logic              run_nl, done_nl, timeout_nl;
  logic [CNT_W-1:0]  cnt_nl;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: edges since release/restart, run-cycle count and exit status.
  int          m_t = 0;
  int unsigned m_cnt = 0;
  bit          m_done = 1'b0;
  bit          m_to = 1'b0;

  always #5 clk = ~clk;

  soc_run_ctrl #(
    .NUM_CH(NUM_CH), .RST_HOLD(RST_HOLD), .STAGGER(STAGGER),
    .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)
  ) u_dut (
    .clk(clk), .rst(rst), .halt_i(halt_i), .restart_i(restart_i),
    .core_rst_o(core_rst_o), .run_o(run_o), .done_o(done_o),
    .timeout_o(timeout_o), .cycle_cnt_o(cycle_cnt_o)
  );

  soc_run_ctrl #(
    .NUM_CH(NUM_CH), .RST_HOLD(RST_HOLD), .STAGGER(STAGGER),
    .CNT_W(CNT_W), .MAX_CYCLES(0)
  ) u_dut_nolim (
    .clk(clk), .rst(rst_nl), .halt_i(halt_nl), .restart_i(restart_nl),
    .core_rst_o(core_rst_nl), .run_o(run_nl), .done_o(done_nl),
    .timeout_o(timeout_nl), .cycle_cnt_o(cnt_nl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_running();
    return !m_done && (m_t >= REL_LAST);
  endfunction

  // Domain k is out of reset once RST_HOLD + k*STAGGER edges have elapsed.
  function automatic logic [NUM_CH-1:0] exp_core_rst();
    logic [NUM_CH-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k] = (m_t < RST_HOLD + k * STAGGER);
    return r;
  endfunction

  task automatic model_reset();
    m_t = 0; m_cnt = 0; m_done = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_edge(input bit h, input bit r);
    bit was_running;
    if (r) begin
      model_reset();
    end else begin
      was_running = m_running();
      m_t++;
      if (was_running) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (h) begin
          m_done = 1'b1; m_to = 1'b0;
        end else if (MAX_CYCLES != 0 && m_cnt == MAX_CYCLES) begin
          m_done = 1'b1; m_to = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".core_rst"}, 32'(core_rst_o), 32'(exp_core_rst()));
    check({tag, ".run"},      32'(run_o),      32'(m_running()));
    check({tag, ".done"},     32'(done_o),     32'(m_done));
    check({tag, ".timeout"},  32'(timeout_o),  32'(m_to));
    check({tag, ".cnt"},      cycle_cnt_o,     m_cnt);
  endtask

  // One clock: drive at negedge, model the posedge, compare at next negedge.
  task automatic cycle(input bit h, input bit r, input string tag);
    halt_i = h;
    restart_i = r;
    @(posedge clk);
    model_edge(h, r);
    @(negedge clk);
    halt_i = 1'b0;
    restart_i = 1'b0;
    compare_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (5) @(negedge clk);
    check("rst.core_rst", 32'(core_rst_o), 32'h3);
    check("rst.run", 32'(run_o), 32'h0);
    check("rst.done", 32'(done_o), 32'h0);
    check("rst.timeout", 32'(timeout_o), 32'h0);
    check("rst.cnt", cycle_cnt_o, 32'h0);
    model_reset();

    // Release sequence, full run to timeout, then 20 cycles of hold.
    rst = 1'b1;
    for (int i = 1; i <= REL_LAST + MAX_CYCLES + 20; i++) begin
      cycle(1'b0, 1'b0, "seq1");
      if (i == 9)  check("edge9.core_rst", 32'(core_rst_o), 32'h3);
      if (i == 10) check("edge10.core_rst", 32'(core_rst_o), 32'h2);
      if (i == 13) check("edge13.run", 32'(run_o), 32'h0);
      if (i == 14) begin
        check("edge14.core_rst", 32'(core_rst_o), 32'h0);
        check("edge14.run", 32'(run_o), 32'h1);
      end
    end
    check("timeout.done", 32'(done_o), 32'h1);
    check("timeout.timeout", 32'(timeout_o), 32'h1);
    check("timeout.cnt", cycle_cnt_o, 32'd50);
    check("timeout.run", 32'(run_o), 32'h0);

    // Restart from DONE, then halt at run cycle 17.
    cycle(1'b0, 1'b1, "restart_done");
    check("restart_done.core_rst", 32'(core_rst_o), 32'h3);
    check("restart_done.done", 32'(done_o), 32'h0);
    check("restart_done.cnt", cycle_cnt_o, 32'h0);
    for (int i = 0; i < 200 && !(m_running() && m_cnt == 17); i++) cycle(1'b0, 1'b0, "pre_halt");
    check("pre_halt.cnt", cycle_cnt_o, 32'd17);
    cycle(1'b1, 1'b0, "halt");
    check("halt.done", 32'(done_o), 32'h1);
    check("halt.timeout", 32'(timeout_o), 32'h0);
    check("halt.cnt", cycle_cnt_o, 32'd18);
    repeat (5) cycle(1'b0, 1'b0, "halt_hold");
    check("halt_hold.cnt", cycle_cnt_o, 32'd18);

    // Halt coincident with the cycle limit: halt wins.
    cycle(1'b0, 1'b1, "restart2");
    for (int i = 0; i < 200 && !(m_running() && m_cnt == MAX_CYCLES - 1); i++) cycle(1'b0, 1'b0, "pre_coinc");
    check("pre_coinc.cnt", cycle_cnt_o, 32'd49);
    cycle(1'b1, 1'b0, "coinc");
    check("coinc.done", 32'(done_o), 32'h1);
    check("coinc.timeout", 32'(timeout_o), 32'h0);
    check("coinc.cnt", cycle_cnt_o, 32'd50);

    // Restart mid-SEQ; the release sequence repeats with identical timing.
    cycle(1'b0, 1'b1, "restart3");
    repeat (12) cycle(1'b0, 1'b0, "seq3");
    check("mid_seq.core_rst", 32'(core_rst_o), 32'h2);
    cycle(1'b0, 1'b1, "restart_seq");
    check("restart_seq.core_rst", 32'(core_rst_o), 32'h3);
    for (int i = 1; i <= REL_LAST; i++) begin
      cycle(1'b0, 1'b0, "seq4");
      if (i == 10) check("re_edge10.core_rst", 32'(core_rst_o), 32'h2);
      if (i == 14) check("re_edge14.run", 32'(run_o), 32'h1);
    end

    // Asynchronous reset mid-run, between clock edges.
    for (int i = 0; i < 200 && !(m_running() && m_cnt == 30); i++) cycle(1'b0, 1'b0, "pre_arst");
    check("pre_arst.cnt", cycle_cnt_o, 32'd30);
    #2 rst = 1'b0;
    #1;
    check("arst.core_rst", 32'(core_rst_o), 32'h3);
    check("arst.run", 32'(run_o), 32'h0);
    check("arst.cnt", cycle_cnt_o, 32'h0);
    check("arst.done", 32'(done_o), 32'h0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Random halts and restarts against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0), "rand");
    end

    // Unlimited run: done never asserts.
    begin
      bit seen_done;
      seen_done = 1'b0;
      rst_nl = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (done_nl) seen_done = 1'b1;
      end
      check("nolim.done_seen", 32'(seen_done), 32'h0);
      check("nolim.run", 32'(run_nl), 32'h1);
      check("nolim.cnt", cnt_nl, 32'(1000 - REL_LAST));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_run_ctrl.md
Name: soc_run_ctrl

Overview:
- Synthesisable run controller for the openmips minimal SoC.
- Releases NUM_CH core-side resets (active-high, RstEnable=1) in sequence: first after a hold period, then one channel every STAGGER cycles.
- Counts run cycles and ends the run on a halt indication or on a cycle-limit timeout.
- Supports soft restart; exposes status so a testbench or debug host can end simulation without a fixed #delay.

Parameters:
- NUM_CH, 2, number of reset domains sequenced; 1..8.
- RST_HOLD, 10, cycles all resets stay asserted after rst release; >=1.
- STAGGER, 4, cycles between successive channel releases; >=1.
- CNT_W, 32, width of run-cycle counter.
- MAX_CYCLES, 50, run-cycle limit; 0 = unlimited.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- halt_i  in  1  CPU halt indication (level), sampled in RUN only.
- restart_i  in  1  soft-restart request, single-cycle pulse.
- core_rst_o  out  NUM_CH  per-domain reset, 1 = held in reset; bit 0 released first.
- run_o  out  1  1 while in RUN.
- done_o  out  1  1 in DONE (halt or timeout).
- timeout_o  out  1  1 in DONE when exit cause was the cycle limit.
- cycle_cnt_o  out  CNT_W  cycles spent in RUN, frozen in DONE.

Behaviour:
- Async reset (rst=0):
  - state=HOLD, core_rst_o=all ones, run_o=0, done_o=0, timeout_o=0, cycle_cnt_o=0, internal counters=0.
  - Takes effect immediately, including mid-sequence or mid-run.
- HOLD:
  - Counts up to RST_HOLD cycles after the first clk edge with rst=1.
  - On count==RST_HOLD-1: clear core_rst_o[0], go to SEQ (NUM_CH>1) or RUN (NUM_CH==1).
- SEQ:
  - Every STAGGER cycles, clear the next core_rst_o bit, lowest index first.
  - When the last bit clears, go to RUN that same cycle.
  - Each output changes on exactly one clk edge and never re-asserts except via reset or restart.
- RUN:
  - run_o=1.
  - cycle_cnt_o increments by 1 each cycle; saturates at all ones, no wrap.
  - Leave for DONE on the cycle after either exit condition is seen:
    - halt_i=1: exit with timeout_o=0.
    - MAX_CYCLES!=0 and cycle_cnt_o==MAX_CYCLES-1 on an edge: exit with timeout_o=1.
  - If halt and limit occur on the same cycle, halt wins: timeout_o=0.
  - core_rst_o stays 0.
- DONE:
  - run_o=0, done_o=1; cycle_cnt_o and timeout_o hold.
  - core_rst_o stays 0, so CPU state remains inspectable.
- restart_i (any state other than reset):
  - Next edge: core_rst_o=all ones, counters=0, done_o=0, timeout_o=0, state=HOLD.
  - restart_i has priority over every other transition on the same cycle.
- Latency:
  - Bit 0 released RST_HOLD edges after rst deassert.
  - Bit k released RST_HOLD+k*STAGGER edges after rst deassert.
  - run_o rises on the same edge as the last release.
- Counters sized with $clog2 of their limits.
- No combinational paths from inputs to outputs; every output is a register.

Decomposition:
- Shared package (defines include):
  - State encoding: HOLD, SEQ, RUN, DONE as 2-bit localparams.
  - RstEnable/RstDisable reused for core_rst_o values.
- One natural sub-module: soc_rst_seq (HOLD/SEQ counters and per-channel release register, NUM_CH/RST_HOLD/STAGGER params).
- The parent holds the RUN/DONE logic and cycle counter.

Test Plan:
- Reset release, defaults (NUM_CH=2, RST_HOLD=10, STAGGER=4): rst=0 for 5 cycles then 1 -> core_rst_o=11 for 10 edges, =10 at edge 10, =00 and run_o=1 at edge 14.
- Timeout (MAX_CYCLES=50, halt_i=0): done_o=1, timeout_o=1, cycle_cnt_o=50, run_o=0; values hold for 20 further cycles.
- Halt: halt_i=1 at RUN cycle 17 -> done_o=1, timeout_o=0, cycle_cnt_o frozen at 18.
- Halt coincident with limit: halt_i=1 on cycle cycle_cnt_o=49 -> timeout_o=0, done_o=1.
- Soft restart in DONE and mid-SEQ: restart_i pulse -> next edge core_rst_o=11, done_o=0, cycle_cnt_o=0; full release sequence repeats with identical timing.
- Async reset mid-RUN: rst=0 between clock edges at cycle 30 -> outputs return to reset values immediately, without waiting for clk. Also run MAX_CYCLES=0 for 1000 cycles -> done_o never asserts.
